// File: rtl/coco_spi_host_pkg.sv
// Shared SPI command definitions for the cocofpga host and target ends:
// command bytes, host op encodings and per-op transaction length.
package coco_spi_host_pkg;

    localparam logic [7:0] SPI_CMD_SETADDR = 8'h01;
    localparam logic [7:0] SPI_CMD_WRITE   = 8'h02;
    localparam logic [7:0] SPI_CMD_READ    = 8'h03;
    localparam logic [7:0] SPI_CMD_STATUS  = 8'h04;
    localparam logic [7:0] SPI_CMD_DEVCON  = 8'h05;

    typedef enum logic [2:0] {
        OP_SETADDR    = 3'd0,
        OP_WRITE      = 3'd1,
        OP_READ       = 3'd2,
        OP_STATUS     = 3'd3,
        OP_DEVCON     = 3'd4,
        OP_ADDR_WRITE = 3'd5,
        OP_ADDR_READ  = 3'd6,
        OP_RSVD       = 3'd7
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } host_state_e;

    function automatic logic [2:0] op_byte_count(input cmd_op_e op);
        case (op)
            OP_SETADDR:                  return 3'd3;
            OP_ADDR_WRITE, OP_ADDR_READ: return 3'd5;
            OP_RSVD:                     return 3'd0;
            default:                     return 3'd2;
        endcase
    endfunction

    function automatic logic op_is_read(input cmd_op_e op);
        return (op == OP_READ) || (op == OP_STATUS) || (op == OP_ADDR_READ);
    endfunction

endpackage

// File: rtl/coco_spi_host_spi_byte_shifter.sv
// Mode-0 SPI byte engine: shifts one byte out MSB-first while sampling the
// synchronised miso at the end of each SCK-high phase.
module coco_spi_host_spi_byte_shifter #(
    parameter int CLK_DIV = 6
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    localparam int HW = $clog2(CLK_DIV);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic [1:0]    miso_sync;
    logic          busy;
    logic          phase;
    logic [HW-1:0] half_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          half_end;

    assign half_end = busy && (half_cnt == HALF_LAST);
    assign done     = half_end && phase && (bit_idx == 3'd7);
    assign sclk     = busy && phase;
    assign mosi     = tx_sr[7];
    assign rx_byte  = rx_sr;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            miso_sync <= 2'b00;
            busy      <= 1'b0;
            phase     <= 1'b0;
            half_cnt  <= '0;
            bit_idx   <= 3'd0;
            tx_sr     <= 8'h00;
            rx_sr     <= 8'h00;
        end else begin
            miso_sync <= {miso_sync[0], miso};
            if (start) begin
                busy     <= 1'b1;
                phase    <= 1'b0;
                half_cnt <= '0;
                bit_idx  <= 3'd0;
                tx_sr    <= tx_byte;
            end else if (half_end) begin
                half_cnt <= '0;
                phase    <= ~phase;
                // End of the high phase: sample, then present the next bit as SCK falls
                if (phase) begin
                    rx_sr   <= {rx_sr[6:0], miso_sync[1]};
                    tx_sr   <= {tx_sr[6:0], 1'b0};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        busy <= 1'b0;
                    end
                end
            end else if (busy) begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coco_spi_host.sv
// SPI host command engine: turns one request into the cocofpga command byte
// sequence, pacing bytes with idle gaps so the target's SRAM arbiter keeps up.
module coco_spi_host
    import coco_spi_host_pkg::*;
#(
    parameter int CLK_DIV    = 6,
    parameter int GAP_CYCLES = 64
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_done,
    output logic [7:0]  rsp_rdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    host_state_e state, state_nxt;
    logic [15:0] cnt;
    logic [2:0]  byte_idx;
    logic [2:0]  last_idx;
    cmd_op_e     op_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  tx_byte;
    logic        shift_start;
    logic        shift_done;
    logic        sh_sclk;
    logic        sh_mosi;
    logic [7:0]  sh_rx;

    function automatic logic [7:0] seq_byte(input cmd_op_e op, input logic [15:0] addr,
                                            input logic [7:0] wdata, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_SETADDR, OP_ADDR_WRITE, OP_ADDR_READ: begin
                case (idx)
                    3'd0:    b = SPI_CMD_SETADDR;
                    3'd1:    b = addr[15:8];
                    3'd2:    b = addr[7:0];
                    3'd3:    b = (op == OP_ADDR_WRITE) ? SPI_CMD_WRITE : SPI_CMD_READ;
                    3'd4:    b = (op == OP_ADDR_WRITE) ? wdata : 8'h00;
                    default: b = 8'h00;
                endcase
            end
            OP_WRITE:  b = (idx == 3'd0) ? SPI_CMD_WRITE : wdata;
            OP_READ:   b = (idx == 3'd0) ? SPI_CMD_READ : 8'h00;
            OP_STATUS: b = (idx == 3'd0) ? SPI_CMD_STATUS : 8'h00;
            OP_DEVCON: b = (idx == 3'd0) ? SPI_CMD_DEVCON : wdata;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    assign last_idx = op_byte_count(op_q) - 3'd1;
    assign tx_byte  = seq_byte(op_q, addr_q, wdata_q, byte_idx);

    coco_spi_host_spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .start    (shift_start),
        .tx_byte  (tx_byte),
        .miso     (miso),
        .sclk     (sh_sclk),
        .mosi     (sh_mosi),
        .rx_byte  (sh_rx),
        .done     (shift_done)
    );

    always_comb begin
        state_nxt   = state;
        shift_start = 1'b0;
        case (state)
            ST_IDLE:    if (cmd_valid) state_nxt = ST_START;
            ST_START:   state_nxt = (op_q == OP_RSVD) ? ST_DONE : ST_SETUP;
            ST_SETUP, ST_GAP: begin
                if (cnt == ((state == ST_SETUP) ? DIV_LAST : GAP_LAST)) begin
                    state_nxt   = ST_SHIFT;
                    shift_start = 1'b1;
                end
            end
            ST_SHIFT:   if (shift_done) state_nxt = (byte_idx == last_idx) ? ST_HOLD : ST_GAP;
            ST_HOLD:    if (cnt == DIV_LAST) state_nxt = ST_RELEASE;
            ST_RELEASE: if (cnt == GAP_LAST) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 16'd0;
            byte_idx  <= 3'd0;
            rsp_rdata <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
            if (state == ST_IDLE) begin
                byte_idx <= 3'd0;
            end else if (state == ST_SHIFT && state_nxt == ST_GAP) begin
                byte_idx <= byte_idx + 3'd1;
            end
            if (state == ST_RELEASE && state_nxt == ST_DONE && op_is_read(op_q)) begin
                rsp_rdata <= sh_rx;
            end
        end
    end

    // Request fields are only meaningful while busy, so they need no reset
    always_ff @(posedge clock_50) begin
        if (state == ST_IDLE && cmd_valid) begin
            op_q    <= cmd_op_e'(cmd_op);
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    always_comb begin
        case (state)
            ST_SETUP, ST_GAP: mosi = tx_byte[7];
            ST_SHIFT:         mosi = sh_mosi;
            default:          mosi = 1'b0;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_done  = (state == ST_DONE);
    assign sclk      = (state == ST_SHIFT) && sh_sclk;
    assign ss        = !((state == ST_SETUP) || (state == ST_SHIFT) ||
                         (state == ST_GAP) || (state == ST_HOLD));

endmodule

// File: tb/tb_coco_spi_host.sv
// Bench for coco_spi_host: a mode-0 SPI target model records mosi bytes and
// returns programmed reply bytes; results are scored against queued expectations.
module tb_coco_spi_host;

    localparam int CD  = 6;
    localparam int GAP = 64;

    logic        clock_50;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_done;
    logic [7:0]  rsp_rdata;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        ss;

    coco_spi_host #(
        .CLK_DIV    (CD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock_50  (clock_50),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss        (ss)
    );

    initial begin
        clock_50 = 1'b0;
        forever #10 clock_50 = ~clock_50;
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  reply;
        int          nbytes;
        logic [39:0] bytes;
        logic [7:0]  exp_rdata;
    } vec_t;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         sck_rises = 0;
    int         ss_rises = 0;
    int         t_rise = 0;
    int         last_high = 0;
    int         tgt_bits = 0;
    int         out_bits = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] tgt_rx = 8'h00;
    logic [7:0] rb;
    logic [7:0] tgt_reply [5];
    logic [7:0] mosi_seen [$];
    logic [7:0] exp_q [$];
    logic [7:0] exp_rsp_q [$];
    vec_t       vecs [8];

    always @(posedge clock_50) cyc++;

    always @(posedge ss) begin
        ss_rises++;
        t_rise = cyc;
    end

    always @(negedge ss) last_high = cyc - t_rise;

    // Target: captures mosi on SCK rise, changes miso on SCK fall
    always @(negedge ss or posedge sclk or negedge sclk) begin
        if (sclk && !prev_sclk) begin
            tgt_rx = {tgt_rx[6:0], mosi};
            tgt_bits++;
            sck_rises++;
            if (tgt_bits % 8 == 0) mosi_seen.push_back(tgt_rx);
        end else if (!sclk && prev_sclk) begin
            out_bits = tgt_bits;
        end else begin
            tgt_bits = 0;
            out_bits = 0;
        end
        prev_sclk = sclk;
        if (out_bits < 40) begin
            rb   = tgt_reply[out_bits / 8];
            miso = rb[7 - (out_bits % 8)];
        end else begin
            miso = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic int exp_latency(input int n);
        if (n == 0) return 1;
        return 1 + CD + n * 16 * CD + (n - 1) * GAP + CD + GAP;
    endfunction

    task automatic set_reply(input int last, input logic [7:0] val);
        for (int i = 0; i < 5; i++) tgt_reply[i] = (i == last) ? val : 8'hEE;
    endtask

    task automatic compare_bytes(input string name);
        check({name, "_nbytes"}, mosi_seen.size(), exp_q.size());
        while (exp_q.size() > 0 && mosi_seen.size() > 0)
            check({name, "_mosi_byte"}, mosi_seen.pop_front(), exp_q.pop_front());
        exp_q.delete();
        mosi_seen.delete();
    endtask

    task automatic run_cmd(input string name, input vec_t v);
        int base_sck;
        int base_ssr;
        int k;
        set_reply(v.nbytes - 1, v.reply);
        for (int i = 0; i < v.nbytes; i++) exp_q.push_back(v.bytes[39 - 8 * i -: 8]);
        exp_rsp_q.push_back(v.exp_rdata);
        @(negedge clock_50);
        check({name, "_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        base_sck  = sck_rises;
        base_ssr  = ss_rises;
        @(posedge clock_50);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        check({name, "_ready_busy"}, cmd_ready, 0);
        k = 0;
        while (k < 3000) begin
            @(posedge clock_50);
            #1;
            k++;
            if (rsp_done) break;
        end
        check({name, "_latency"}, k, exp_latency(v.nbytes));
        check({name, "_rdata"}, rsp_rdata, exp_rsp_q.pop_front());
        check({name, "_sck_rises"}, sck_rises - base_sck, 8 * v.nbytes);
        check({name, "_ss_rises"}, ss_rises - base_ssr, (v.nbytes > 0) ? 1 : 0);
        @(posedge clock_50);
        #1;
        check({name, "_done_pulse"}, rsp_done, 0);
        check({name, "_ready_after"}, cmd_ready, 1);
        compare_bytes(name);
    endtask

    initial begin
        int k;
        int dones;
        int base;
        vec_t wv;

        vecs[0] = '{3'd1, 16'h0000, 8'hA5, 8'hC7, 2, 40'h02A5000000, 8'h00};
        vecs[1] = '{3'd2, 16'h0000, 8'h11, 8'h3C, 2, 40'h0300000000, 8'h3C};
        vecs[2] = '{3'd7, 16'h1234, 8'h99, 8'hC7, 0, 40'h0000000000, 8'h3C};
        vecs[3] = '{3'd6, 16'hFF4B, 8'h00, 8'h81, 5, 40'h01FF4B0300, 8'h81};
        vecs[4] = '{3'd0, 16'h1234, 8'h77, 8'hC7, 3, 40'h0112340000, 8'h81};
        vecs[5] = '{3'd3, 16'h0000, 8'h00, 8'h5A, 2, 40'h0400000000, 8'h5A};
        vecs[6] = '{3'd5, 16'h00C3, 8'h7E, 8'hC7, 5, 40'h0100C3027E, 8'h5A};
        vecs[7] = '{3'd4, 16'h0000, 8'h06, 8'hC7, 2, 40'h0506000000, 8'h5A};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 8'h00;
        set_reply(0, 8'hEE);
        repeat (3) @(posedge clock_50);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_done", rsp_done, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ss", ss, 1);
        @(negedge clock_50);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_cmd($sformatf("v%0d", i), vecs[i]);

        // cmd_valid held high across two DEVCON transactions
        set_reply(1, 8'hC7);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h06);
        @(negedge clock_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_wdata = 8'h06;
        dones = 0;
        k = 0;
        while (k < 2000 && dones < 2) begin
            @(posedge clock_50);
            #1;
            k++;
            if (rsp_done) dones++;
        end
        cmd_valid = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_ss_high_ge_gap", (last_high >= GAP) ? 1 : 0, 1);
        repeat (3) @(posedge clock_50);
        #1;
        check("b2b_idle_after", cmd_ready, 1);
        check("b2b_ss_after", ss, 1);
        compare_bytes("b2b");

        // Reset asserted during the third byte of SETADDR
        set_reply(2, 8'hC7);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hBE);
        base = sck_rises;
        @(negedge clock_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_addr  = 16'hBEEF;
        @(posedge clock_50);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while (k < 2000 && sck_rises < base + 19) begin
            @(posedge clock_50);
            #1;
            k++;
        end
        check("rst_mid_reached_byte3", (sck_rises >= base + 19) ? 1 : 0, 1);
        #3 reset_n = 1'b0;
        #1;
        check("rst_mid_ss", ss, 1);
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_mosi", mosi, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_done", rsp_done, 0);
        check("rst_mid_rdata", rsp_rdata, 0);
        @(posedge clock_50);
        #1;
        reset_n = 1'b1;
        dones = 0;
        repeat (700) begin
            @(posedge clock_50);
            #1;
            if (rsp_done) dones++;
        end
        check("rst_mid_no_done", dones, 0);
        check("rst_mid_ss_idle", ss, 1);
        compare_bytes("rst_mid");

        wv = '{3'd1, 16'h0000, 8'h3C, 8'hC7, 2, 40'h023C000000, 8'h00};
        run_cmd("post_rst_write", wv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
